// File: rtl/instr_fetch_queue_if.sv
// rtl/instr_fetch_queue_if.sv - fetch-side and decode-side handshake bundle for instr_fetch_queue
interface instr_fetch_queue_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int DEPTH  = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_instr;
  logic [PC_W-1:0]   in_pc;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [PC_W-1:0]   out_pc;
  logic              flush;
  logic [CW-1:0]     count;

  modport master (
    output in_valid, in_instr, in_pc, out_ready, flush,
    input  in_ready, out_valid, out_instr, out_pc, count
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready, flush,
    output in_ready, out_valid, out_instr, out_pc, count
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - circular {pc, instr} buffer between instruction memory and decode
// Flush on redirect discards wrong-path words, optionally keeping the branch delay slot.
module instr_fetch_queue #(
  parameter int DATA_W    = 32,
  parameter int PC_W      = 32,
  parameter int DEPTH     = 4,
  parameter int KEEP_SLOT = 0
) (
  input  logic                clock,
  input  logic                reset_n,
  instr_fetch_queue_if.slave  q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] instr_mem_q [DEPTH];
  logic [PC_W-1:0]   pc_mem_q    [DEPTH];

  logic              push;
  logic              pop;
  logic              wr_en;
  logic [CW-1:0]     remain;

  always_comb begin
    push     = q.in_valid && (count_q < CW'(DEPTH));
    pop      = q.out_ready && (count_q != '0);
    wr_en    = push && !(q.flush && (KEEP_SLOT == 0));
    remain   = count_q - CW'(pop) + CW'(push);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (q.flush) begin
      if (KEEP_SLOT == 0) begin
        rd_ptr_d = wr_ptr_q;
        count_d  = '0;
      end else begin
        // Survivor is the oldest word left after this cycle's pop and push.
        rd_ptr_d = rd_ptr_q + AW'(pop);
        if (remain != '0) begin
          wr_ptr_d = rd_ptr_d + AW'(1);
          count_d  = CW'(1);
        end else begin
          wr_ptr_d = rd_ptr_d;
          count_d  = '0;
        end
      end
    end else begin
      rd_ptr_d = rd_ptr_q + AW'(pop);
      wr_ptr_d = wr_ptr_q + AW'(push);
      count_d  = remain;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage holds no reset; occupancy alone decides what is visible.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      instr_mem_q[wr_ptr_q] <= q.in_instr;
      pc_mem_q[wr_ptr_q]    <= q.in_pc;
    end
  end

  assign q.in_ready  = (count_q < CW'(DEPTH));
  assign q.out_valid = (count_q != '0);
  assign q.out_instr = q.out_valid ? instr_mem_q[rd_ptr_q] : '0;
  assign q.out_pc    = q.out_valid ? pc_mem_q[rd_ptr_q] : '0;
  assign q.count     = count_q;
endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Parametrised instruction buffer between instruction memory (i_datain source) and the decode stage of the pipelined MIPS CPU.
- Replaces the single-word fetch register: holds up to DEPTH {pc, instruction} pairs under valid/ready handshakes on both sides.
- On a control-flow redirect (j, jal, jr or taken branch, i.e. pcSrcD) it flushes wrong-path entries. An optional mode preserves the branch delay slot.

Parameters:
DATA_W, 32, instruction width in bits
PC_W, 32, program-counter width in bits
DEPTH, 4, number of entries (power of two, >= 2)
KEEP_SLOT, 0, 1 = on flush keep the oldest entry (delay slot); 0 = discard all entries

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  fetch side presents a word
in_ready  output  1  queue can accept a word this cycle
in_instr  input  DATA_W  fetched instruction
in_pc  input  PC_W  pc of fetched instruction
out_valid  output  1  head entry valid for decode
out_ready  input  1  decode consumes head this cycle
out_instr  output  DATA_W  head instruction
out_pc  output  PC_W  head pc
flush  input  1  redirect from decode (j/jal/jr/taken branch)
count  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (async, reset_n=0): count=0, rd/wr pointers=0, out_valid=0, in_ready=1. out_instr/out_pc read 0 while empty. Storage contents are don't-care.
- Reset mid-operation clears all entries immediately, with no clock needed. The first push after reset_n rises is accepted on the next rising edge.
- Push: accepted when in_valid & in_ready at the rising edge.
- Pop: occurs when out_valid & out_ready at the rising edge.
- in_ready = (count < DEPTH). It is registered-state based and never depends on out_ready (no combinational path ready-to-ready).
- out_valid = (count != 0). out_instr/out_pc are driven combinationally from the head entry (zero added latency).
- Latency: a word pushed into an empty queue is visible at out_* the cycle after the push edge.
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
- Full (count=DEPTH): in_ready=0. A pop that cycle frees a slot for the next cycle only.
- Empty: a pop request is ignored. Both pointers wrap modulo DEPTH.
- Flush (sampled at the rising edge, highest priority):
  - KEEP_SLOT=0: count<=0 and pointers equalised. Any same-cycle push and pop are discarded.
  - KEEP_SLOT=1, pop also asserted: the head is consumed, then the next-oldest entry (if any) becomes the sole survivor. count<=1 if that entry existed, else 0.
  - KEEP_SLOT=1, no pop: the head survives. count<=1 if count!=0.
  - KEEP_SLOT=1, queue empty and push asserted: the pushed word is kept as the delay slot (count<=1).
- count never exceeds DEPTH or underflows.
- Assertion for the bench: pushes are never lost unless flushed, and output order equals push order.

Test Plan:
- Reset, then push pc 0x0,0x4,0x8,0xC (instr 0x8C010005, 0x8C020002, 0x8C040003, 0x8C050004) with out_ready=0 -> count=4, in_ready=0, out_pc=0x0, out_instr=0x8C010005.
- From full, out_ready=1 for 4 cycles with no push -> outputs 0x8C010005, 0x8C020002, 0x8C040003, 0x8C050004 in order. count ends 0 and out_valid=0.
- Steady stream, push and pop every cycle for 10 cycles (pc 0x10..0x34) -> count stays 1, each word appears one cycle after its push, pointers wrap without loss.
- KEEP_SLOT=0: 3 entries (jump 0x08000000 at head), assert flush with a push of 0x0C000001 that cycle -> next cycle count=0, out_valid=0, pushed word dropped.
- KEEP_SLOT=1: entries pc 0x20 (jr 0x00200008), 0x24, 0x28; flush with out_ready=1 -> next cycle count=1, out_pc=0x24 (delay slot kept), 0x28 discarded.
- Deassert reset_n between clock edges while count=3 -> count=0 and out_valid=0 immediately. After release, a push at the next edge gives count=1.
